// File: rtl/jt89_noise_pkg.sv
// Shared constants for the jt89 noise channel: NF encodings, control bit layout
// and LFSR geometry. JT89_NOISE_SMS_EN selects the Sega 16-bit LFSR over the TI 15-bit one.
package jt89_noise_pkg;

    typedef enum logic [1:0] {
        NF_512   = 2'd0,
        NF_1024  = 2'd1,
        NF_2048  = 2'd2,
        NF_TONE2 = 2'd3
    } nf_e;

    localparam int FB_BIT = 2;

`ifdef JT89_NOISE_SMS_EN
    localparam int LFSR_W = 16;
    localparam int TAP_B  = 3;
`else
    localparam int LFSR_W = 15;
    localparam int TAP_B  = 1;
`endif
    localparam int TAP_A = 0;
    localparam logic [LFSR_W-1:0] LFSR_SEED = {1'b1, {(LFSR_W-1){1'b0}}};

endpackage

// File: rtl/jt89_noise_if.sv
// Control/data bundle between the PSG register file and the noise channel.
interface jt89_noise_if;
    logic       clk_en;
    logic       ctrl_we;
    logic [2:0] ctrl;
    logic       tone2;
    logic       dout;

    modport master (output clk_en, ctrl_we, ctrl, tone2, input dout);
    modport slave  (input clk_en, ctrl_we, ctrl, tone2, output dout);
endinterface

// File: rtl/jt89_noise_lfsr.sv
// Noise shift register: reload to seed on load, right shift with periodic or white feedback.
module jt89_noise_lfsr
    import jt89_noise_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              white,
    output logic [LFSR_W-1:0] q
);

    logic fb;

    assign fb = white ? (q[TAP_A] ^ q[TAP_B]) : q[0];

    always_ff @(posedge clk) begin
        if (rst || load)
            q <= LFSR_SEED;
        else if (shift)
            q <= {fb, q[LFSR_W-1:1]};
    end

endmodule

// File: rtl/jt89_noise.sv
// SN76489 noise channel: rate divider / tone-2 edge detect feeding the LFSR.
// Build with JT89_NOISE_SMS_EN for the Sega 16-bit LFSR variant.
module jt89_noise
    import jt89_noise_pkg::*;
#(
    parameter int BASE_PERIOD = 16,
    parameter int CNT_W       = 7
) (
    input logic         clk,
    input logic         rst,
    jt89_noise_if.slave bus
);

    logic [2:0]        ctrl_r;
    logic [CNT_W-1:0]  cnt;
    logic              phase;
    logic              tone2_d;
    logic              ext;
    logic              shift;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;

    // NF=3 has no divider period; any reload works since the divider is frozen there
    function automatic logic [CNT_W-1:0] reload(input logic [1:0] nf);
        case (nf_e'(nf))
            NF_1024: reload = CNT_W'(2*BASE_PERIOD - 1);
            NF_2048: reload = CNT_W'(4*BASE_PERIOD - 1);
            default: reload = CNT_W'(BASE_PERIOD - 1);
        endcase
    endfunction

    assign ext = (nf_e'(ctrl_r[1:0]) == NF_TONE2);

    // A control write in the same cycle suppresses the shift
    always_comb begin
        shift = 1'b0;
        if (bus.clk_en && !bus.ctrl_we)
            shift = ext ? (bus.tone2 && !tone2_d) : ((cnt == '0) && !phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r  <= '0;
            cnt     <= CNT_W'(BASE_PERIOD - 1);
            phase   <= 1'b0;
            tone2_d <= 1'b0;
        end else if (bus.ctrl_we) begin
            ctrl_r  <= bus.ctrl;
            cnt     <= reload(bus.ctrl[1:0]);
            phase   <= 1'b0;
            tone2_d <= bus.tone2;
        end else if (bus.clk_en) begin
            if (ext) begin
                tone2_d <= bus.tone2;
            end else if (cnt == '0) begin
                cnt   <= reload(ctrl_r[1:0]);
                phase <= ~phase;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    jt89_noise_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (bus.ctrl_we),
        .shift (shift),
        .white (ctrl_r[FB_BIT]),
        .q     (lfsr)
    );

    assign bus.dout    = lfsr[0];
    assign lfsr_unused = ^lfsr[LFSR_W-1:1];

endmodule

// File: tb/tb_jt89_noise.sv
// Bench for jt89_noise: tick-schedule reference model with a scoreboard queue,
// a table of write/run vectors, and hand sequences for tone2, collisions and reset.
module tb_jt89_noise;

`ifdef JT89_NOISE_SMS_EN
    localparam int          W    = 16;
    localparam logic [15:0] SEED = 16'h8000;
    localparam int          TAP  = 3;
`else
    localparam int          W    = 15;
    localparam logic [15:0] SEED = 16'h4000;
    localparam int          TAP  = 1;
`endif
    localparam int BASE = 16;

    typedef struct {
        logic [15:0] lfsr;
        logic        dout;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        int          ticks;
        logic [15:0] lfsr;
        logic        dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    jt89_noise_if bus();

    jt89_noise #(.BASE_PERIOD(BASE), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [15:0] m_lfsr;
    logic [2:0]  m_ctrl;
    int          m_ticks;
    logic        m_t2d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic m_shift();
        logic fb;
        fb = m_ctrl[2] ? (m_lfsr[0] ^ m_lfsr[TAP]) : m_lfsr[0];
        m_lfsr = (m_lfsr >> 1) | (16'(fb) << (W - 1));
    endtask

    // Shifts land at ticks P, 3P, 5P... counted from the last write/reset
    task automatic m_edge(input logic en, input logic we, input logic [2:0] c,
                          input logic t2, input logic r);
        int p;
        if (r) begin
            m_ctrl = 3'b000; m_lfsr = SEED; m_ticks = 0; m_t2d = 1'b0;
        end else if (we) begin
            m_ctrl = c; m_lfsr = SEED; m_ticks = 0; m_t2d = t2;
        end else if (en) begin
            if (m_ctrl[1:0] == 2'd3) begin
                if (t2 && !m_t2d) m_shift();
                m_t2d = t2;
            end else begin
                p = BASE << m_ctrl[1:0];
                m_ticks++;
                if (m_ticks >= p && ((m_ticks - p) % (2*p)) == 0) m_shift();
            end
        end
    endtask

    task automatic step(input logic en, input logic we, input logic [2:0] c,
                        input logic t2, input logic r);
        exp_t e;
        bus.clk_en = en; bus.ctrl_we = we; bus.ctrl = c; bus.tone2 = t2; rst = r;
        m_edge(en, we, c, t2, r);
        exp_q.push_back('{lfsr: m_lfsr, dout: m_lfsr[0]});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("seq", 32'({bus.dout, 16'(dut.lfsr)}), 32'({e.dout, e.lfsr}));
    endtask

    task automatic run(input int n, input logic t2);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'b000, t2, 1'b0);
    endtask

    task automatic wr(input logic [2:0] c, input logic t2);
        step(1'b0, 1'b1, c, t2, 1'b0);
    endtask

    task automatic check_state(input string name, input logic [15:0] l);
        check(name, 32'(dut.lfsr), 32'(l));
        check({name, "_dout"}, 32'(bus.dout), 32'(l[0]));
    endtask

    vec_t vecs[12];

    initial begin
`ifdef JT89_NOISE_SMS_EN
        vecs[0]  = '{"per13",  3'b000, 400, 16'h0004, 1'b0};
        vecs[1]  = '{"per15",  3'b000, 464, 16'h0001, 1'b1};
        vecs[2]  = '{"per16",  3'b000, 496, 16'h8000, 1'b0};
        vecs[3]  = '{"wht12",  3'b100, 368, 16'h0008, 1'b0};
        vecs[4]  = '{"wht13",  3'b100, 400, 16'h8004, 1'b0};
        vecs[5]  = '{"nf2_63", 3'b010,  63, 16'h8000, 1'b0};
        vecs[6]  = '{"nf2_64", 3'b010,  64, 16'h4000, 1'b0};
        vecs[7]  = '{"nf2_191",3'b010, 191, 16'h4000, 1'b0};
        vecs[8]  = '{"nf2_192",3'b010, 192, 16'h2000, 1'b0};
        vecs[9]  = '{"nf1_32", 3'b001,  32, 16'h4000, 1'b0};
        vecs[10] = '{"nf1_95", 3'b001,  95, 16'h4000, 1'b0};
        vecs[11] = '{"nf1_96", 3'b001,  96, 16'h2000, 1'b0};
`else
        vecs[0]  = '{"per13",  3'b000, 400, 16'h0002, 1'b0};
        vecs[1]  = '{"per14",  3'b000, 432, 16'h0001, 1'b1};
        vecs[2]  = '{"per15",  3'b000, 464, 16'h4000, 1'b0};
        vecs[3]  = '{"wht13",  3'b100, 400, 16'h0002, 1'b0};
        vecs[4]  = '{"wht14",  3'b100, 432, 16'h4001, 1'b1};
        vecs[5]  = '{"nf2_63", 3'b010,  63, 16'h4000, 1'b0};
        vecs[6]  = '{"nf2_64", 3'b010,  64, 16'h2000, 1'b0};
        vecs[7]  = '{"nf2_191",3'b010, 191, 16'h2000, 1'b0};
        vecs[8]  = '{"nf2_192",3'b010, 192, 16'h1000, 1'b0};
        vecs[9]  = '{"nf1_32", 3'b001,  32, 16'h2000, 1'b0};
        vecs[10] = '{"nf1_95", 3'b001,  95, 16'h2000, 1'b0};
        vecs[11] = '{"nf1_96", 3'b001,  96, 16'h1000, 1'b0};
`endif

        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        check_state("rst_lfsr", SEED);
        check("rst_cnt", 32'(dut.cnt), 32'(BASE - 1));
        check("rst_phase", 32'(dut.phase), 32'd0);
        check("rst_ctrl", 32'(dut.ctrl_r), 32'd0);
        check("rst_t2d", 32'(dut.tone2_d), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            wr(vecs[i].ctrl, 1'b0);
            run(vecs[i].ticks, 1'b0);
            check(vecs[i].name, 32'(dut.lfsr), 32'(vecs[i].lfsr));
            check({vecs[i].name, "_dout"}, 32'(bus.dout), 32'(vecs[i].dout));
        end

        // white sequence past the hand-checked prefix, scoreboard only
        wr(3'b100, 1'b0);
        run(432 + 100*32, 1'b0);

        // write lands on the tick a shift is due
        wr(3'b000, 1'b0);
        run(15, 1'b0);
        step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        check_state("coll_seed", SEED);
        run(15, 1'b0);
        check_state("coll_hold", SEED);
        run(1, 1'b0);
        check_state("coll_next", SEED >> 1);

        // switch to tone2 rate mid-count: no stray shift
        wr(3'b000, 1'b0);
        run(20, 1'b0);
        check_state("nf0_run", SEED >> 1);
        wr(3'b011, 1'b0);
        run(40, 1'b0);
        check_state("nf0to3", SEED);
        for (int k = 0; k < 6; k++) begin
            run(5, 1'b1);
            run(5, 1'b0);
        end
        check_state("t2_rise", SEED >> 6);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
        check_state("t2_en0", SEED >> 6);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        run(3, 1'b0);
        check_state("t2_en0b", SEED >> 6);
        run(1, 1'b1);
        check_state("t2_next", SEED >> 7);

        // reset mid-sequence with clk_en low
        step(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        check_state("rmid_lfsr", SEED);
        check("rmid_cnt", 32'(dut.cnt), 32'(BASE - 1));
        check("rmid_phase", 32'(dut.phase), 32'd0);
        check("rmid_ctrl", 32'(dut.ctrl_r), 32'd0);
        check("rmid_t2d", 32'(dut.tone2_d), 32'd0);
        run(15, 1'b0);
        check_state("rmid_hold", SEED);
        run(1, 1'b0);
        check_state("rmid_next", SEED >> 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
